// File: rtl/sigmoid_pwl_pipe.sv
// sigmoid_pwl_pipe: streaming fixed-point sigmoid/tanh unit.
// It uses a shift-and-add piecewise-linear (PLAN) curve and a
// three-stage valid/ready pipeline with bubble-collapsing backpressure.
// S1 (_p1): fold sign, optionally double for tanh, take |x|, pick segment.
// S2 (_p2): evaluate the segment's shift-and-add line.
// S3 (output register): mirror for negative inputs, rescale for tanh.
module sigmoid_pwl_pipe #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16
) (
    input  logic                     aclk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_data,
    input  logic                     s_mode,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [DATA_W-1:0] m_data
);

    localparam logic [DATA_W-1:0] MAX_POS  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] ONE_U    = DATA_W'(1) << FRAC_W;
    localparam logic signed [DATA_W:0] ONE_W = {1'b0, ONE_U};
    // Segment thresholds: 1.0, 2.375 (19/8), 5.0
    localparam logic [DATA_W-1:0] TH_SEG1  = ONE_U;
    localparam logic [DATA_W-1:0] TH_SEG2  = DATA_W'(19) << (FRAC_W - 3);
    localparam logic [DATA_W-1:0] TH_SEG3  = DATA_W'(5) << FRAC_W;
    // Line offsets: 0.5, 0.625 (5/8), 0.84375 (27/32)
    localparam logic [DATA_W-1:0] C_SEG0   = DATA_W'(1) << (FRAC_W - 1);
    localparam logic [DATA_W-1:0] C_SEG1   = DATA_W'(5) << (FRAC_W - 3);
    localparam logic [DATA_W-1:0] C_SEG2   = DATA_W'(27) << (FRAC_W - 5);

    // Double x with saturation. Overflow happens exactly when the two top bits differ.
    function automatic logic signed [DATA_W-1:0] sat_dbl(input logic signed [DATA_W-1:0] x);
        if (x[DATA_W-1] != x[DATA_W-2])
            return x[DATA_W-1] ? $signed(MIN_NEG) : $signed(MAX_POS);
        return {x[DATA_W-2:0], 1'b0};
    endfunction

    // Magnitude of x. The most-negative value clamps to the largest positive value.
    function automatic logic [DATA_W-1:0] abs_sat(input logic signed [DATA_W-1:0] x);
        if ($unsigned(x) == MIN_NEG)
            return MAX_POS;
        return x[DATA_W-1] ? (~$unsigned(x) + 1'b1) : $unsigned(x);
    endfunction

    // Segment select. Each threshold is inclusive on its lower edge.
    function automatic logic [1:0] seg_of(input logic [DATA_W-1:0] a);
        if (a >= TH_SEG3) return 2'd3;
        if (a >= TH_SEG2) return 2'd2;
        if (a >= TH_SEG1) return 2'd1;
        return 2'd0;
    endfunction

    // Shift-and-add line for the selected segment. The shifts truncate.
    function automatic logic [DATA_W-1:0] pwl(input logic [DATA_W-1:0] a, input logic [1:0] seg);
        case (seg)
            2'd0:    return (a >> 2) + C_SEG0;
            2'd1:    return (a >> 3) + C_SEG1;
            2'd2:    return (a >> 5) + C_SEG2;
            default: return ONE_U;
        endcase
    endfunction

    // Mirror about 0.5 for negative x, then map [0,1] onto [-1,1] for tanh.
    // One extra bit keeps 2y from overflowing before 1.0 is subtracted.
    function automatic logic signed [DATA_W-1:0] finish(input logic [DATA_W-1:0] y,
                                                        input logic sgn, input logic mode);
        logic signed [DATA_W:0] v;
        v = $signed({1'b0, y});
        if (sgn)  v = ONE_W - v;
        if (mode) v = (v <<< 1) - ONE_W;
        return v[DATA_W-1:0];
    endfunction

    logic                     vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d, vld_p3_q, vld_p3_d;
    logic                     adv_p2, adv_p3, ld_p1, ld_p2, ld_p3;
    logic signed [DATA_W-1:0] xs_p0;
    logic [DATA_W-1:0]        a_p1_q, a_p1_d, y_p2_q, y_p2_d;
    logic [1:0]               seg_p1_q, seg_p1_d;
    logic                     sgn_p1_q, sgn_p1_d, mode_p1_q, mode_p1_d;
    logic                     sgn_p2_q, sgn_p2_d, mode_p2_q, mode_p2_d;
    logic signed [DATA_W-1:0] m_data_q, m_data_d;

    // Handshake: a stage loads when it is empty or its content moves on this cycle
    always_comb begin
        adv_p3   = !vld_p3_q || m_ready;
        adv_p2   = !vld_p2_q || adv_p3;
        s_ready  = !vld_p1_q || adv_p2;
        ld_p1    = s_valid && s_ready;
        ld_p2    = vld_p1_q && adv_p2;
        ld_p3    = vld_p2_q && adv_p3;
        vld_p1_d = s_ready ? s_valid  : vld_p1_q;
        vld_p2_d = adv_p2  ? vld_p1_q : vld_p2_q;
        vld_p3_d = adv_p3  ? vld_p2_q : vld_p3_q;
    end

    // Datapath next values for all three stages
    always_comb begin
        // S1: sign/mode capture, tanh doubling, magnitude, segment
        xs_p0     = s_mode ? sat_dbl(s_data) : s_data;
        a_p1_d    = abs_sat(xs_p0);
        seg_p1_d  = seg_of(a_p1_d);
        sgn_p1_d  = s_data[DATA_W-1];
        mode_p1_d = s_mode;
        // S2: line evaluation
        y_p2_d    = pwl(a_p1_q, seg_p1_q);
        sgn_p2_d  = sgn_p1_q;
        mode_p2_d = mode_p1_q;
        // S3: symmetry and tanh rescale
        m_data_d  = finish(y_p2_q, sgn_p2_q, mode_p2_q);
    end

    // Valid bits and the visible output word are cleared asynchronously
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            m_data_q <= '0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            vld_p3_q <= vld_p3_d;
            if (ld_p3) m_data_q <= m_data_d;
        end
    end

    // Internal data registers only need load enables; their valid bits qualify them
    always_ff @(posedge aclk) begin
        if (ld_p1) begin
            a_p1_q    <= a_p1_d;
            seg_p1_q  <= seg_p1_d;
            sgn_p1_q  <= sgn_p1_d;
            mode_p1_q <= mode_p1_d;
        end
        if (ld_p2) begin
            y_p2_q    <= y_p2_d;
            sgn_p2_q  <= sgn_p2_d;
            mode_p2_q <= mode_p2_d;
        end
    end

    assign m_valid = vld_p3_q;
    assign m_data  = m_data_q;

endmodule
